alu_flag_reg: RTL and testbench

Registered, parametrised ALU status-flag unit for the ALU/register-file datapath. Takes each ALU result with its carry and overflow bits, computes a true 1-bit zero flag through a two-stage chunked OR reduction, and holds zero/negative/carry/overflow flags until the next valid result. It also maintains a sticky "any non-zero seen" bit and a saturating count of zero results for branch and test logic. It sits between the ALU output and the branch/condition logic.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/or_reduce_chunk.sv | 11 +
 rtl/alu_flag_reg.sv | 130 +++++++++++++
 tb/tb_alu_flag_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and the status-flag bundle used by the flag register
// and by the downstream branch/condition logic.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_CHUNK = 8;
   localparam int ALU_CNT_W = 8;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;

   function automatic int num_chunks(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/or_reduce_chunk.sv
// First-level OR group of the zero detector: one bit set anywhere in the chunk.
module or_reduce_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] in_bits,
   output logic             any_set
);

   assign any_set = |in_bits;

endmodule

// File: rtl/alu_flag_reg.sv
// Two-stage registered ALU status flags (zero/neg/carry/ovf) with a sticky
// non-zero bit and a saturating zero-result counter.
module alu_flag_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CHUNK = ALU_CHUNK,
   parameter int CNT_W = ALU_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_carry,
   input  logic             in_ovf,
   input  logic             clr,
   output logic             out_valid,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             sticky_nz,
   output logic [CNT_W-1:0] zero_cnt
);

   localparam int NCH  = num_chunks(WIDTH, CHUNK);
   localparam int PADW = NCH * CHUNK;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [PADW-1:0] data_pad;
   logic [NCH-1:0]  chunk_or;

   // Top chunk may be partial; the unused bits read as zero.
   always_comb begin
      data_pad = '0;
      data_pad[WIDTH-1:0] = in_data;
   end

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
         or_reduce_chunk #(.CHUNK(CHUNK)) u_or (
            .in_bits (data_pad[gi*CHUNK +: CHUNK]),
            .any_set (chunk_or[gi])
         );
      end
   endgenerate

   logic             v1_q, v1_d;
   logic [NCH-1:0]   chunk_or_q, chunk_or_d;
   logic             msb1_q, msb1_d;
   logic             carry1_q, carry1_d;
   logic             ovf1_q, ovf1_d;
   alu_flags_t       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             result_zero;

   assign result_zero = ~|chunk_or_q;

   always_comb begin
      v1_d       = in_valid;
      chunk_or_d = chunk_or_q;
      msb1_d     = msb1_q;
      carry1_d   = carry1_q;
      ovf1_d     = ovf1_q;
      if (in_valid) begin
         chunk_or_d = chunk_or;
         msb1_d     = in_data[WIDTH-1];
         carry1_d   = in_carry;
         ovf1_d     = in_ovf;
      end

      out_valid_d = v1_q;
      flags_d     = flags_q;
      if (v1_q) begin
         flags_d.zero  = result_zero;
         flags_d.neg   = msb1_q;
         flags_d.carry = carry1_q;
         flags_d.ovf   = ovf1_q;
      end

      // clr beats a result arriving in the same cycle; that result is not counted.
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (v1_q) begin
         if (!result_zero) begin
            sticky_d = 1'b1;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         chunk_or_q  <= '0;
         msb1_q      <= 1'b0;
         carry1_q    <= 1'b0;
         ovf1_q      <= 1'b0;
         flags_q     <= '{zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
         out_valid_q <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         v1_q        <= v1_d;
         chunk_or_q  <= chunk_or_d;
         msb1_q      <= msb1_d;
         carry1_q    <= carry1_d;
         ovf1_q      <= ovf1_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign carry     = flags_q.carry;
   assign ovf       = flags_q.ovf;
   assign sticky_nz = sticky_q;
   assign zero_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_flag_reg.sv
// Scoreboard bench: instance 0 uses the default 32/8/8 shape, instance 1 a
// 12-bit partial-chunk shape with a 2-bit saturating counter.
module tb_alu_flag_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  in_valid = '0, in_carry = '0, in_ovf = '0, clr = '0;
   logic [31:0] d0 = '0;
   logic [11:0] d1 = '0;
   logic [1:0]  ov, z, n, c, o, s;
   logic [7:0]  cnt0;
   logic [1:0]  cnt1;

   alu_flag_reg #(.WIDTH(32), .CHUNK(8), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(d0),
      .in_carry(in_carry[0]), .in_ovf(in_ovf[0]), .clr(clr[0]),
      .out_valid(ov[0]), .zero(z[0]), .neg(n[0]), .carry(c[0]), .ovf(o[0]),
      .sticky_nz(s[0]), .zero_cnt(cnt0));

   alu_flag_reg #(.WIDTH(12), .CHUNK(8), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(d1),
      .in_carry(in_carry[1]), .in_ovf(in_ovf[1]), .clr(clr[1]),
      .out_valid(ov[1]), .zero(z[1]), .neg(n[1]), .carry(c[1]), .ovf(o[1]),
      .sticky_nz(s[1]), .zero_cnt(cnt1));

   typedef struct {
      bit zero, neg, carry, ovf, sticky;
      int cnt;
   } exp_t;

   typedef struct {
      bit v;
      bit [31:0] d;
      bit c, o;
   } item_t;

   exp_t  sb0[$];
   exp_t  sb1[$];
   item_t p1[2];
   bit    m_sticky[2];
   int    m_cnt[2];
   bit [3:0] last[2];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   // Reference: the result captured on the previous edge finishes on the next one.
   task automatic put(input int i, input bit v, input bit [31:0] d, input bit cy, input bit ov_in, input bit cl);
      bit [31:0] mask = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
      int w    = (i == 0) ? 32 : 12;
      int cmax = (i == 0) ? 255 : 3;
      exp_t e;
      if (p1[i].v) begin
         e.zero  = ((p1[i].d & mask) == 0);
         e.neg   = p1[i].d[w-1];
         e.carry = p1[i].c;
         e.ovf   = p1[i].o;
         if (cl) begin
            m_sticky[i] = 1'b0;
            m_cnt[i]    = 0;
         end else if (e.zero) begin
            if (m_cnt[i] < cmax) m_cnt[i]++;
         end else begin
            m_sticky[i] = 1'b1;
         end
         e.sticky = m_sticky[i];
         e.cnt    = m_cnt[i];
         if (i == 0) sb0.push_back(e); else sb1.push_back(e);
      end else if (cl) begin
         m_sticky[i] = 1'b0;
         m_cnt[i]    = 0;
      end
      p1[i] = '{v: v, d: d, c: cy, o: ov_in};
      in_valid[i] = v;
      in_carry[i] = cy;
      in_ovf[i]   = ov_in;
      clr[i]      = cl;
      if (i == 0) d0 = d; else d1 = d[11:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle2();
      put(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      put(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic flush_model();
      sb0.delete();
      sb1.delete();
      for (int i = 0; i < 2; i++) begin
         p1[i]       = '{v: 1'b0, d: 32'h0, c: 1'b0, o: 1'b0};
         m_sticky[i] = 1'b0;
         m_cnt[i]    = 0;
         last[i]     = 4'b1000;
      end
   endtask

   task automatic mon(input int i, input logic v, input logic zz, input logic nn, input logic cc,
                      input logic oo, input logic ss, input logic [7:0] cn);
      exp_t e;
      if (v) begin
         if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
            chk("unexpected_out_valid", i, 32'd1, 32'd0);
         end else begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            $display("inst%0d result zero=%0b neg=%0b carry=%0b ovf=%0b sticky=%0b cnt=%0d",
                     i, zz, nn, cc, oo, ss, cn);
            chk("zero", i, {31'b0, zz}, {31'b0, e.zero});
            chk("neg", i, {31'b0, nn}, {31'b0, e.neg});
            chk("carry", i, {31'b0, cc}, {31'b0, e.carry});
            chk("ovf", i, {31'b0, oo}, {31'b0, e.ovf});
            chk("sticky_nz", i, {31'b0, ss}, {31'b0, e.sticky});
            chk("zero_cnt", i, {24'b0, cn}, e.cnt);
            last[i] = {e.zero, e.neg, e.carry, e.ovf};
         end
      end else begin
         chk("flag_hold", i, {28'b0, zz, nn, cc, oo}, {28'b0, last[i]});
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", 0, {30'b0, ov}, 32'd0);
         chk("rst_flags0", 0, {28'b0, z[0], n[0], c[0], o[0]}, 32'h8);
         chk("rst_flags1", 1, {28'b0, z[1], n[1], c[1], o[1]}, 32'h8);
         chk("rst_acc", 0, {20'b0, s, cnt0, cnt1}, 32'd0);
      end else begin
         mon(0, ov[0], z[0], n[0], c[0], o[0], s[0], cnt0);
         mon(1, ov[1], z[1], n[1], c[1], o[1], s[1], {6'b0, cnt1});
      end
   end

   function automatic bit [31:0] rdata();
      case ($urandom_range(0, 3))
         0:       return 32'h0;
         1:       return 32'h1 << $urandom_range(0, 31);
         2:       return $urandom;
         default: return ~(32'h1 << $urandom_range(0, 31));
      endcase
   endfunction

   task automatic do_reset();
      tick();
      rst_n    = 1'b0;
      in_valid = 2'b11;
      d0       = $urandom;
      d1       = 12'hABC;
      flush_model();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle2();
      tick(); idle2();
      tick(); idle2();
   endtask

   initial begin
      flush_model();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(); idle2();
      tick(); idle2();

      // Zero detect on inst0, partial chunk on inst1.
      tick(); put(0, 1, 32'h0000_0000, 0, 0, 0); put(1, 1, 32'h800, 0, 0, 0);
      tick(); put(0, 1, 32'h8000_0000, 0, 0, 0); put(1, 1, 32'h000, 0, 0, 0);
      tick(); put(0, 1, 32'h0000_0001, 0, 0, 0); put(1, 1, 32'h010, 0, 0, 0);
      // Carry/overflow alignment.
      tick(); put(0, 1, 32'h7FFF_FFFF, 1, 0, 0); put(1, 1, 32'h7FF, 0, 1, 0);
      tick(); put(0, 1, 32'h8000_0000, 0, 1, 0); put(1, 1, 32'hFFF, 1, 0, 0);
      tick(); idle2();
      // Saturation on inst1: clear, then five zero results.
      tick(); put(0, 0, 0, 0, 0, 0); put(1, 0, 0, 0, 0, 1);
      for (int k = 0; k < 5; k++) begin
         tick(); put(0, 1, 32'h0, 0, 0, 0); put(1, 1, 32'h0, 0, 0, 0);
      end
      tick(); idle2();
      // clr collides with a non-zero result reaching stage 2.
      tick(); put(0, 1, 32'h0000_0009, 0, 0, 0); put(1, 1, 32'h100, 0, 0, 0);
      tick(); put(0, 0, 0, 0, 0, 1); put(1, 0, 0, 0, 0, 1);
      tick(); idle2();
      tick(); idle2();

      for (int cyc = 0; cyc < 240; cyc++) begin
         if (cyc == 120) do_reset();
         tick();
         for (int i = 0; i < 2; i++) begin
            put(i, $urandom_range(0, 3) != 0, rdata(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
         end
      end
      tick(); idle2();
      repeat (3) tick();
      chk("drain0", 0, sb0.size(), 32'd0);
      chk("drain1", 1, sb1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
